data_memory_map: RTL and testbench
==================================

# data_memory_map

Data-side memory map for the single-cycle RISC-V core. It consumes the core's `MemWrite`, `MemRead`, `Result` (address) and `rd2` (store data) outputs and returns load data on `data_o_map`. It decodes each access to one of three targets: a word-addressed data RAM, a GPIO block, or an 8N1 UART transmitter. Reads are combinational so single-cycle loads complete in the same cycle; all writes and peripheral state update on the clock edge.

## Interface
- `DATA_WIDTH`, 32, data bus width
- `ADDR_WIDTH`, 32, address bus width
- `RAM_DEPTH`, 64, data RAM depth in 32-bit words (power of two)
- `CLKS_PER_BIT`, 16, clock cycles per UART bit (≥2)

Ports:
- `clk`  in  1  core clock; single clock domain
- `rst`  in  1  reset; synchronous and active-high
- `MemWrite`  in  1  store strobe from control unit
- `MemRead`  in  1  load strobe from control unit
- `addr`  in  ADDR_WIDTH  byte address (core ALU `Result`)
- `wdata`  in  DATA_WIDTH  store data (core `rd2`)
- `data_o_map`  out  DATA_WIDTH  load data to core write-back mux
- `gpio_in`  in  8  asynchronous input pins
- `gpio_out`  out  8  output pins
- `uart_tx`  out  1  serial TX line, idle high

## Operation
- All accesses are word accesses. `addr[1:0]` is ignored.
- Address map:
  - RAM: 0x1001_0000 to 0x1001_0000 + 4·RAM_DEPTH − 1. Word index is `addr[log2(RAM_DEPTH)+1:2]`.
  - UART_TX 0x1001_0400: write only.
  - UART_STAT 0x1001_0404: read/write.
  - GPIO_OUT 0x1001_0408: read/write.
  - GPIO_IN 0x1001_040C: read only.
- Reads:
  - `data_o_map` is 0 when `MemRead`=0, or when the address is unmapped or write-only.
  - Otherwise it is combinationally the selected RAM word or register, zero-extended to 32 bits.
- Writes occur at the rising edge when `MemWrite`=1. Writes to unmapped or read-only addresses have no effect.
- If `MemRead` and `MemWrite` are both high, the read returns the pre-write value.
- RAM:
  - Not cleared by reset; contents are undefined until written.
  - Written in full 32-bit words.
- GPIO_OUT:
  - 8-bit register, loaded from `wdata[7:0]`.
  - Drives `gpio_out`. Reset value 0x00.
- GPIO_IN:
  - `gpio_in` passes through a 2-flop synchronizer; the read returns the second flop.
  - Synchronizer flops reset to 0.
- UART_STAT read value: bit0 = busy (state ≠ IDLE), bit1 = done; all other bits 0.
  - done is sticky. It is set on the edge that completes a frame.
  - Any write to UART_STAT clears done. If set and clear occur on the same edge, set wins.
- UART transmitter FSM, states IDLE → START → DATA → STOP → IDLE:
  - IDLE: `uart_tx`=1. A UART_TX write while in IDLE latches `wdata[7:0]` into the shift register and moves to START at that edge.
  - A UART_TX write while not IDLE is dropped silently. This includes the last STOP cycle.
  - START: `uart_tx`=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each for CLKS_PER_BIT cycles. A 3-bit index counts 0..7.
  - STOP: `uart_tx`=1 for CLKS_PER_BIT cycles, then IDLE and done set.
- Baud counter: counts 0..CLKS_PER_BIT−1 within each bit and resets to 0 on every state or bit change.
- `uart_tx` is driven from a register, so no combinational glitches.

## Timing
- Reset values: FSM IDLE, baud counter 0, bit index 0, shift register 0x00, `uart_tx`=1, done=0, `gpio_out`=0x00, synchronizer 0.
- Reset taken mid-frame aborts the frame: `uart_tx`=1 from the next edge and done stays 0.
- Load latency: 0 cycles, combinational from `addr` and `MemRead`.
- Store latency: the value is visible to reads in the cycle after the edge.
- GPIO_IN latency: a pin change appears in reads 2 edges later.
- UART frame, with the write accepted at edge N:
  - `uart_tx`=0 from N to N+CPB.
  - Data bit i occupies N+(1+i)·CPB to N+(2+i)·CPB.
  - Stop bit occupies N+9·CPB to N+10·CPB.
  - At edge N+10·CPB the FSM returns to IDLE and done=1.
  - busy reads 1 for cycles N through N+10·CPB−1.
- The earliest next accepted UART_TX write is captured at edge N+10·CPB+1 or later.

## Test plan
- Reset, then read each register → UART_STAT=0x0, GPIO_OUT=0x0, `uart_tx`=1, `data_o_map`=0 with `MemRead`=0.
- Store 0xDEADBEEF to 0x1001_0000 and 0xCAFEF00D to 0x1001_00FC, then load both → exact values; load from 0x1001_0200 → 0.
- Write 0x1A5 to GPIO_OUT → `gpio_out`=0xA5 and read=0x000000A5. Drive `gpio_in`=0x3C → GPIO_IN reads 0x3C two edges later, and 0 before that.
- CPB=16: write 0x55 to UART_TX → `uart_tx` sampled mid-bit reads 0,1,0,1,0,1,0,1,0,1. busy=1 for 160 cycles, then UART_STAT=0x2. Write UART_STAT → 0x0.
- Write 0x41 then 0x42 to UART_TX 5 cycles apart → only 0x41 is sent; the second write is dropped.
- Assert `rst` at cycle 50 of a frame → `uart_tx`=1 and UART_STAT=0 after the edge. A new write after reset sends a full frame.

Source files
------------

// File: rtl/data_memory_map.sv
// data_memory_map: data-side memory map for the single-cycle core.
// Decodes word accesses to a data RAM, a GPIO block and an 8N1 UART
// transmitter. Loads are combinational; stores and peripheral state
// update on the rising clock edge.
module data_memory_map #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned RAM_DEPTH    = 64,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] data_o_map,
    input  logic [7:0]            gpio_in,
    output logic [7:0]            gpio_out,
    output logic                  uart_tx
);

    localparam int unsigned RAM_AW    = $clog2(RAM_DEPTH);
    localparam int unsigned BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    localparam logic [ADDR_WIDTH-1:0] RAM_BASE       = ADDR_WIDTH'(32'h1001_0000);
    localparam logic [ADDR_WIDTH-1:0] UART_TX_ADDR   = ADDR_WIDTH'(32'h1001_0400);
    localparam logic [ADDR_WIDTH-1:0] UART_STAT_ADDR = ADDR_WIDTH'(32'h1001_0404);
    localparam logic [ADDR_WIDTH-1:0] GPIO_OUT_ADDR  = ADDR_WIDTH'(32'h1001_0408);
    localparam logic [ADDR_WIDTH-1:0] GPIO_IN_ADDR   = ADDR_WIDTH'(32'h1001_040C);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;

    // Address decode (byte offset bits are ignored: word accesses only)
    logic              hit_ram;
    logic              hit_uart_tx;
    logic              hit_uart_stat;
    logic              hit_gpio_out;
    logic              hit_gpio_in;
    logic [RAM_AW-1:0] ram_idx;
    logic              unused_addr_bits;

    assign hit_ram       = (addr[ADDR_WIDTH-1:RAM_AW+2] == RAM_BASE[ADDR_WIDTH-1:RAM_AW+2]);
    assign hit_uart_tx   = (addr[ADDR_WIDTH-1:2] == UART_TX_ADDR[ADDR_WIDTH-1:2]);
    assign hit_uart_stat = (addr[ADDR_WIDTH-1:2] == UART_STAT_ADDR[ADDR_WIDTH-1:2]);
    assign hit_gpio_out  = (addr[ADDR_WIDTH-1:2] == GPIO_OUT_ADDR[ADDR_WIDTH-1:2]);
    assign hit_gpio_in   = (addr[ADDR_WIDTH-1:2] == GPIO_IN_ADDR[ADDR_WIDTH-1:2]);
    assign ram_idx       = addr[RAM_AW+1:2];
    assign unused_addr_bits = ^addr[1:0];

    // Data RAM and peripheral state
    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

    logic [7:0]  gpio_out_q, gpio_out_d;
    logic [7:0]  sync1_q, sync1_d;
    logic [7:0]  sync2_q, sync2_d;

    uart_state_e       state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              frame_done;
    logic              busy;

    assign busy     = (state_q != ST_IDLE);
    assign gpio_out = gpio_out_q;
    assign uart_tx  = tx_q;

    // RAM write port; contents deliberately not touched by reset
    always_ff @(posedge clk) begin
        if (MemWrite && hit_ram) begin
            mem_q[ram_idx] <= wdata;
        end
    end

    // GPIO next-state: output register load and 2-flop input synchronizer
    always_comb begin
        gpio_out_d = gpio_out_q;
        if (MemWrite && hit_gpio_out) begin
            gpio_out_d = wdata[7:0];
        end
        sync1_d = gpio_in;
        sync2_d = sync1_q;
    end

    // GPIO registers
    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
        end else begin
            gpio_out_q <= gpio_out_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
        end
    end

    // UART state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // UART next-state: frame sequencing and baud/bit counting
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        frame_done = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (MemWrite && hit_uart_tx) begin
                    state_d = ST_START;
                    baud_d  = '0;
                    bit_d   = '0;
                    shift_d = wdata[7:0];
                end
            end
            ST_START: begin
                if (baud_q == BAUD_LAST) begin
                    state_d = ST_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    state_d    = ST_IDLE;
                    baud_d     = '0;
                    frame_done = 1'b1;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // UART outputs: registered line level from the next state; sticky done
    // with frame completion taking priority over a status-write clear
    always_comb begin
        unique case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[bit_d];
            default:  tx_d = 1'b1;
        endcase
        done_d = done_q;
        if (MemWrite && hit_uart_stat) begin
            done_d = 1'b0;
        end
        if (frame_done) begin
            done_d = 1'b1;
        end
    end

    // Combinational load mux; zero when not reading or target is unreadable
    always_comb begin
        data_o_map = '0;
        if (MemRead) begin
            if (hit_ram) begin
                data_o_map = mem_q[ram_idx];
            end else if (hit_uart_stat) begin
                data_o_map[1:0] = {done_q, busy};
            end else if (hit_gpio_out) begin
                data_o_map[7:0] = gpio_out_q;
            end else if (hit_gpio_in) begin
                data_o_map[7:0] = sync2_q;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_map.sv
// Scoreboard bench for data_memory_map: stimulus pushes expected values,
// a negedge monitor pops and compares against the DUT outputs.
module tb_data_memory_map;

    localparam int unsigned CPB   = 16;
    localparam int unsigned FRAME = 10 * CPB;

    localparam logic [31:0] RAM0    = 32'h1001_0000;
    localparam logic [31:0] RAMTOP  = 32'h1001_00FC;
    localparam logic [31:0] UTX     = 32'h1001_0400;
    localparam logic [31:0] USTAT   = 32'h1001_0404;
    localparam logic [31:0] GOUT    = 32'h1001_0408;
    localparam logic [31:0] GIN     = 32'h1001_040C;

    localparam int K_DATA = 0;
    localparam int K_GPIO = 1;
    localparam int K_TX   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data_o_map;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        uart_tx;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int checks   = 0;
    int failures = 0;

    data_memory_map #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (32),
        .RAM_DEPTH    (64),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .addr       (addr),
        .wdata      (wdata),
        .data_o_map (data_o_map),
        .gpio_in    (gpio_in),
        .gpio_out   (gpio_out),
        .uart_tx    (uart_tx)
    );

    always #5 clk = ~clk;

    // Monitor: compare every pending expectation against the DUT mid-cycle
    always @(negedge clk) begin
        sb_item_t    it;
        logic [31:0] act;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            case (it.kind)
                K_GPIO:  act = {24'h0, gpio_out};
                K_TX:    act = {31'h0, uart_tx};
                default: act = data_o_map;
            endcase
            checks++;
            if (act !== it.exp) begin
                failures++;
                $display("FAIL %s actual=0x%08h expected=0x%08h", it.name, act, it.exp);
            end
        end
    end

    task automatic set_bus(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
        MemWrite = we;
        MemRead  = re;
        addr     = a;
        wdata    = d;
    endtask

    task automatic expect_val(input string nm, input int kind, input logic [31:0] exp);
        sb_item_t it;
        it.name = nm;
        it.kind = kind;
        it.exp  = exp;
        sb.push_back(it);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d);
        set_bus(1'b1, 1'b0, a, d);
        step();
        set_bus(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic read_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
        set_bus(1'b0, 1'b1, a, 32'h0);
        expect_val(nm, K_DATA, exp);
        step();
        set_bus(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Sends byte b and watches `cycles` cycles of the frame: busy on every
    // cycle, line level mid-bit. Optional dropped second write and a status
    // clear on the final STOP cycle.
    task automatic watch_frame(input string nm, input logic [7:0] b, input int unsigned cycles,
                               input int second_at, input bit clear_last);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        write(UTX, {24'h0, b});
        for (int unsigned c = 0; c < cycles; c++) begin
            if (int'(c) == second_at) begin
                set_bus(1'b1, 1'b1, UTX, 32'h0000_0042);
                expect_val({nm, "_wo_read"}, K_DATA, 32'h0);
            end else if (clear_last && c == FRAME - 1) begin
                set_bus(1'b1, 1'b1, USTAT, 32'h0);
                expect_val({nm, "_busy_last"}, K_DATA, 32'h1);
            end else begin
                set_bus(1'b0, 1'b1, USTAT, 32'h0);
                expect_val($sformatf("%s_busy%0d", nm, c), K_DATA, 32'h1);
            end
            if (c % CPB == CPB / 2) begin
                expect_val($sformatf("%s_bit%0d", nm, c / CPB), K_TX, {31'h0, frame[c / CPB]});
            end
            step();
        end
        set_bus(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        gpio_in = 8'h00;
        set_bus(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();
        rst = 1'b0;

        // Reset state
        set_bus(1'b0, 1'b1, USTAT, 32'h0);
        expect_val("rst_stat", K_DATA, 32'h0);
        expect_val("rst_tx", K_TX, 32'h1);
        expect_val("rst_gpio_out", K_GPIO, 32'h0);
        step();
        read_chk("rst_gout_read", GOUT, 32'h0);
        read_chk("rst_gin_read", GIN, 32'h0);
        set_bus(1'b0, 1'b0, USTAT, 32'h0);
        expect_val("no_read_zero", K_DATA, 32'h0);
        step();

        // RAM
        write(RAM0, 32'hDEAD_BEEF);
        write(RAMTOP, 32'hCAFE_F00D);
        read_chk("ram_first", RAM0, 32'hDEAD_BEEF);
        read_chk("ram_last", RAMTOP, 32'hCAFE_F00D);
        read_chk("ram_byteoff", RAM0 + 32'h2, 32'hDEAD_BEEF);
        read_chk("unmapped_200", 32'h1001_0200, 32'h0);
        read_chk("unmapped_100", 32'h1001_0100, 32'h0);
        read_chk("uart_tx_wo", UTX, 32'h0);
        set_bus(1'b0, 1'b0, RAM0, 32'h0);
        expect_val("ram_no_read", K_DATA, 32'h0);
        step();
        set_bus(1'b1, 1'b1, RAM0, 32'h1234_5678);
        expect_val("ram_rdw_old", K_DATA, 32'hDEAD_BEEF);
        step();
        read_chk("ram_rdw_new", RAM0, 32'h1234_5678);
        read_chk("ram_last_kept", RAMTOP, 32'hCAFE_F00D);

        // GPIO
        write(GOUT, 32'h0000_01A5);
        set_bus(1'b0, 1'b1, GOUT, 32'h0);
        expect_val("gpio_out_pin", K_GPIO, 32'hA5);
        expect_val("gpio_out_read", K_DATA, 32'hA5);
        step();
        write(GIN, 32'h0000_00FF);
        read_chk("gpio_in_ro", GIN, 32'h0);
        gpio_in = 8'h3C;
        read_chk("gpio_in_e0", GIN, 32'h0);
        read_chk("gpio_in_e1", GIN, 32'h0);
        read_chk("gpio_in_e2", GIN, 32'h3C);

        // UART frame 0x55
        watch_frame("u55", 8'h55, FRAME, -1, 1'b0);
        set_bus(1'b0, 1'b1, USTAT, 32'h0);
        expect_val("u55_done", K_DATA, 32'h2);
        expect_val("u55_idle_tx", K_TX, 32'h1);
        step();
        read_chk("u55_done_sticky", USTAT, 32'h2);
        write(USTAT, 32'h0);
        read_chk("u55_cleared", USTAT, 32'h0);

        // Dropped second write; status clear on completing edge loses to set
        watch_frame("u41", 8'h41, FRAME, 5, 1'b1);
        read_chk("u41_set_wins", USTAT, 32'h2);
        write(USTAT, 32'h0);
        read_chk("u41_cleared", USTAT, 32'h0);

        // Reset mid-frame
        watch_frame("u0f", 8'h0F, 50, -1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_bus(1'b0, 1'b1, USTAT, 32'h0);
        expect_val("mid_rst_stat", K_DATA, 32'h0);
        expect_val("mid_rst_tx", K_TX, 32'h1);
        expect_val("mid_rst_gpio_out", K_GPIO, 32'h0);
        step();
        for (int i = 0; i < 20; i++) begin
            set_bus(1'b0, 1'b1, USTAT, 32'h0);
            expect_val($sformatf("post_rst_idle%0d", i), K_DATA, 32'h0);
            expect_val($sformatf("post_rst_tx%0d", i), K_TX, 32'h1);
            step();
        end
        read_chk("ram_survives_rst", RAM0, 32'h1234_5678);

        // Full frame after reset
        watch_frame("ua3", 8'hA3, FRAME, -1, 1'b0);
        read_chk("ua3_done", USTAT, 32'h2);

        step();
        step();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
